// File: rtl/difftest_uart_in_source.sv
// difftest_uart_in_source
// Simulation-side responder for the difftest UART input channel. The host
// pushes characters into a small FIFO. The DUT samples one character per
// uart_in_valid cycle. After each delivered character, a pacing counter can
// hold back the next one for a fixed number of cycles, which emulates a
// finite line rate. Refused pushes, idle reads and delivered characters are
// counted for end-of-run statistics.

module difftest_uart_in_source #(
    parameter int          DEPTH      = 16,
    parameter int          GAP_CYCLES = 0,
    parameter logic [7:0]  IDLE_CHAR  = 8'hff,
    localparam int         PW         = $clog2(DEPTH),
    localparam int         LW         = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    input  logic [7:0]    push_ch,
    output logic          push_ready,
    input  logic          uart_in_valid,
    output logic [7:0]    uart_in_ch,
    output logic          avail,
    output logic [LW-1:0] level,
    output logic [31:0]   overflow_cnt,
    output logic [31:0]   underflow_cnt,
    output logic [31:0]   read_cnt
);

    // The gap counter must hold GAP_CYCLES. It is kept at least one bit
    // wide, so the GAP_CYCLES == 0 build still elaborates.
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic {
        ST_READY = 1'b0,  // gap == 0, head of FIFO may be shown
        ST_WAIT  = 1'b1   // pacing in progress, head is hidden
    } pace_state_t;

    // Saturating increment shared by the three statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

    pace_state_t   state, state_next;
    logic [GW-1:0] gap, gap_next;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level_q;

    logic full, empty;
    logic push_ok, pop, underflow, overflow;

    // ---------------------------------------------------------------------
    // Status and handshake decode
    // ---------------------------------------------------------------------
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // push_ready comes from the registered level only. A pop in the same
    // cycle therefore cannot make room for a push into a full FIFO.
    assign push_ready = !full;
    assign push_ok    = push_valid && !full;
    assign overflow   = push_valid && full;

    assign avail      = !empty && (state == ST_READY);
    assign pop        = uart_in_valid && avail;
    assign underflow  = uart_in_valid && !avail;

    // Zero-latency read path: the DUT samples this in the same cycle that it
    // raises uart_in_valid.
    assign uart_in_ch = avail ? mem[rd_ptr] : IDLE_CHAR;
    assign level      = level_q;

    // ---------------------------------------------------------------------
    // Pacing FSM
    // ---------------------------------------------------------------------

    // Register the pacing state and its countdown.
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge value, whatever the order of the
    // statements.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_READY;
            gap   <= '0;
        end else begin
            state <= state_next;
            gap   <= gap_next;
        end
    end

    // Next-state logic: a pop arms the gap, and WAIT counts it down to zero.
    // NOTE: defaults are assigned first, so no path leaves a signal unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        gap_next   = gap;
        case (state)
            ST_READY: begin
                if (pop && (GAP_CYCLES != 0)) begin
                    gap_next   = GW'(GAP_CYCLES);
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                gap_next = gap - GW'(1);
                if (gap == GW'(1)) begin
                    state_next = ST_READY;
                end
            end
            default: begin
                state_next = ST_READY;
                gap_next   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------------

    // Write an accepted character into the slot at wr_ptr.
    // NOTE: the storage array has no reset. Only the pointers and the level
    // define which entries are valid, and resetting the array would prevent
    // a plain RAM from being inferred.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_ch;
        end
    end

    // Advance the pointers and track occupancy. Both pointers wrap naturally,
    // because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level_q <= level_q + LW'(push_ok) - LW'(pop);
        end
    end

    // ---------------------------------------------------------------------
    // Statistics
    // ---------------------------------------------------------------------

    // Count refused pushes, idle reads and delivered characters, saturating.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_cnt  <= '0;
            underflow_cnt <= '0;
            read_cnt      <= '0;
        end else begin
            if (overflow) begin
                overflow_cnt <= sat_inc(overflow_cnt);
            end
            if (underflow) begin
                underflow_cnt <= sat_inc(underflow_cnt);
            end
            if (pop) begin
                read_cnt <= sat_inc(read_cnt);
            end
        end
    end

endmodule

// File: tb/tb_difftest_uart_in_source.sv
// tb_difftest_uart_in_source
// Two instances share all inputs: one with back-to-back delivery and one
// paced by three cycles. A queue-based model predicts every output of both
// instances on every cycle. The next character becomes visible at an
// absolute cycle number computed from the last pop.

module tb_difftest_uart_in_source;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       push_valid = 1'b0;
    logic [7:0] push_ch = 8'h00;
    logic       uart_in_valid = 1'b0;

    logic          push_ready_w [2];
    logic          avail_w      [2];
    logic [7:0]    ch_w         [2];
    logic [LW-1:0] level_w      [2];
    logic [31:0]   ovf_w        [2];
    logic [31:0]   udf_w        [2];
    logic [31:0]   rd_w         [2];

    always #5 clock = ~clock;

    difftest_uart_in_source #(.DEPTH(DEPTH), .GAP_CYCLES(0), .IDLE_CHAR(8'hff)) dut0 (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ch(push_ch), .push_ready(push_ready_w[0]),
        .uart_in_valid(uart_in_valid), .uart_in_ch(ch_w[0]), .avail(avail_w[0]),
        .level(level_w[0]), .overflow_cnt(ovf_w[0]), .underflow_cnt(udf_w[0]),
        .read_cnt(rd_w[0])
    );

    difftest_uart_in_source #(.DEPTH(DEPTH), .GAP_CYCLES(3), .IDLE_CHAR(8'hff)) dut1 (
        .clock(clock), .reset(reset),
        .push_valid(push_valid), .push_ch(push_ch), .push_ready(push_ready_w[1]),
        .uart_in_valid(uart_in_valid), .uart_in_ch(ch_w[1]), .avail(avail_w[1]),
        .level(level_w[1]), .overflow_cnt(ovf_w[1]), .underflow_cnt(udf_w[1]),
        .read_cnt(rd_w[1])
    );

    // Reference model state, one slot per instance.
    logic [7:0] mq [2][$];
    longint     ready_at [2];
    longint     m_ovf [2];
    longint     m_udf [2];
    longint     m_rd  [2];
    longint     cyc;

    logic [7:0] seen_ch [2];
    int n_checks = 0;
    int n_errors = 0;

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hffff_ffff) ? v : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            ready_at[i] = 0;
            m_ovf[i] = 0;
            m_udf[i] = 0;
            m_rd[i]  = 0;
        end
    endtask

    // One clock cycle. Drive the inputs, compare every output at the falling
    // edge, then advance the model at the rising edge.
    task automatic cycle(input logic pv, input logic [7:0] pc, input logic uv, input logic rst_n);
        push_valid = pv;
        push_ch = pc;
        uart_in_valid = uv;
        reset = rst_n;
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            int         sz;
            logic       full;
            logic       av;
            logic [7:0] ech;
            sz   = mq[i].size();
            full = (sz == DEPTH);
            av   = (sz > 0) && (cyc >= ready_at[i]);
            ech  = av ? mq[i][0] : 8'hff;
            check($sformatf("push_ready%0d", i), 32'(push_ready_w[i]), 32'(!full));
            check($sformatf("avail%0d", i), 32'(avail_w[i]), 32'(av));
            check($sformatf("uart_in_ch%0d", i), 32'(ch_w[i]), 32'(ech));
            check($sformatf("level%0d", i), 32'(level_w[i]), 32'(sz));
            check($sformatf("overflow_cnt%0d", i), ovf_w[i], m_ovf[i][31:0]);
            check($sformatf("underflow_cnt%0d", i), udf_w[i], m_udf[i][31:0]);
            check($sformatf("read_cnt%0d", i), rd_w[i], m_rd[i][31:0]);
            seen_ch[i] = ch_w[i];
        end
        @(posedge clock);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic full;
                logic av;
                full = (mq[i].size() == DEPTH);
                av   = (mq[i].size() > 0) && (cyc >= ready_at[i]);
                if (uv && !av) m_udf[i] = sat_inc(m_udf[i]);
                if (pv && full) m_ovf[i] = sat_inc(m_ovf[i]);
                if (uv && av) begin
                    void'(mq[i].pop_front());
                    m_rd[i] = sat_inc(m_rd[i]);
                    ready_at[i] = cyc + 1 + gap_of(i);
                end
                if (pv && !full) mq[i].push_back(pc);
            end
        end
        cyc++;
        #1;
        push_valid = 1'b0;
        uart_in_valid = 1'b0;
        reset = 1'b1;
        push_ch = 8'($urandom);
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_hi [3];
        logic [7:0] exp_gap [5];
        int p_push;
        int p_read;
        exp_hi  = '{8'h68, 8'h69, 8'hff};
        exp_gap = '{8'h41, 8'hff, 8'hff, 8'hff, 8'h42};
        cyc = 0;
        model_clear();

        // Bring both instances out of their unknown power-up state.
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Reset, then idle, then a single read of an empty FIFO.
        repeat (5) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("idle_push_ready", 32'(push_ready_w[0]), 32'd1);
        check("idle_avail", 32'(avail_w[0]), 32'd0);
        check("idle_ch", 32'(ch_w[0]), 32'hff);
        check("idle_level", 32'(level_w[0]), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check("idle_underflow", udf_w[0], 32'd1);
        check("idle_read_cnt", rd_w[0], 32'd0);

        // Back-to-back delivery of "hi", followed by one idle read.
        do_reset();
        cycle(1'b1, 8'h68, 1'b0, 1'b1);
        cycle(1'b1, 8'h69, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            check($sformatf("hi_char%0d", k), 32'(seen_ch[0]), 32'(exp_hi[k]));
        end
        check("hi_read_cnt", rd_w[0], 32'd2);
        check("hi_underflow", udf_w[0], 32'd1);
        check("hi_level", 32'(level_w[0]), 32'd0);

        // Eighteen pushes into sixteen slots, then drain across the wrap.
        do_reset();
        for (int k = 0; k < 18; k++) cycle(1'b1, 8'(8'h10 + k), 1'b0, 1'b1);
        check("fill_level", 32'(level_w[0]), 32'd16);
        check("fill_overflow", ovf_w[0], 32'd2);
        check("fill_push_ready", 32'(push_ready_w[0]), 32'd0);
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            check($sformatf("drain_char%0d", k), 32'(seen_ch[0]), 32'(8'h10 + k));
        end
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'h30 + k), 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            check($sformatf("wrap_char%0d", k), 32'(seen_ch[0]), 32'(8'h30 + k));
        end

        // Paced instance: 'A' is delivered, then three idle cycles, then 'B'.
        do_reset();
        cycle(1'b1, 8'h41, 1'b0, 1'b1);
        cycle(1'b1, 8'h42, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            check($sformatf("gap_char%0d", k), 32'(seen_ch[1]), 32'(exp_gap[k]));
        end
        check("gap_underflow", udf_w[1], 32'd3);
        check("gap_read_cnt", rd_w[1], 32'd2);

        // A full FIFO with push and pop in the same cycle.
        do_reset();
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
        cycle(1'b1, 8'h77, 1'b1, 1'b1);
        check("full_pp_overflow", ovf_w[0], 32'd1);
        check("full_pp_level", 32'(level_w[0]), 32'd15);
        cycle(1'b1, 8'h78, 1'b0, 1'b1);
        check("full_pp_refill", 32'(level_w[0]), 32'd16);

        // A reset in mid-stream, with a read pending during the reset cycle.
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'h50 + k), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("mid_rst_level", 32'(level_w[0]), 32'd0);
        check("mid_rst_avail", 32'(avail_w[0]), 32'd0);
        check("mid_rst_ovf", ovf_w[0], 32'd0);
        check("mid_rst_udf", udf_w[0], 32'd0);
        check("mid_rst_rd", rd_w[0], 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check("mid_rst_read", 32'(seen_ch[0]), 32'hff);

        // Random traffic, with push and read densities varying by phase.
        for (int ph = 0; ph < 15; ph++) begin
            p_push = $urandom_range(10, 95);
            p_read = $urandom_range(10, 95);
            for (int k = 0; k < 200; k++) begin
                cycle(($urandom_range(0, 99) < p_push) ? 1'b1 : 1'b0,
                      8'($urandom),
                      ($urandom_range(0, 99) < p_read) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/difftest_uart_in_source.md
Name: difftest_uart_in_source

Overview:
- Testbench-side responder for the difftest UART input channel: buffers host-supplied characters and returns them to the DUT when it samples `difftest_uart_in`.
- Replaces the constant 8'hff tie-off. Sits in the simulation top between a host push port (DPI or plusarg loader) and the DUT's `uart_in_valid`/`uart_in_ch` pins.
- Includes a FIFO, an inter-character pacing counter emulating line rate, and overflow/underflow statistics.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 0, minimum clock cycles after a pop before the next character becomes visible; 0 means back-to-back.
- IDLE_CHAR, 8'hff, value driven on `uart_in_ch` when no character is available.

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-low reset
- push_valid  input  1  host offers a character
- push_ch  input  8  character from host
- push_ready  output  1  FIFO can accept; equals !full
- uart_in_valid  input  1  DUT reads a character this cycle
- uart_in_ch  output  8  character returned to the DUT
- avail  output  1  a character is visible to the DUT this cycle
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow_cnt  output  32  push_valid cycles refused because the FIFO was full
- underflow_cnt  output  32  uart_in_valid cycles answered with IDLE_CHAR
- read_cnt  output  32  characters actually delivered

Behaviour:
- Reset:
  - `reset` is synchronous, active-low; clock is `clock`. On a rising edge with reset==0:
    - rd_ptr, wr_ptr and level cleared.
    - gap counter cleared, so the state is READY.
    - All three counters cleared.
  - Resulting outputs: push_ready=1, avail=0, uart_in_ch=IDLE_CHAR.
  - Reset mid-stream discards buffered characters; no partial pop occurs.
- FIFO:
  - Circular buffer of DEPTH x 8. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - full when level==DEPTH; empty when level==0.
  - Push accepted iff push_valid && !full. The data is written at wr_ptr on the clock edge.
- Pacing state machine (2 states):
  - READY: gap==0.
  - WAIT: gap!=0; gap decrements by 1 each cycle. WAIT->READY when gap reaches 1 (it decrements to 0).
  - A pop loads gap<=GAP_CYCLES. With GAP_CYCLES==0 the block never leaves READY.
- Visibility and read (zero latency):
  - avail = !empty && state==READY.
  - uart_in_ch = avail ? mem[rd_ptr] : IDLE_CHAR. Combinational; the DUT samples it in the same cycle it asserts uart_in_valid.
- Pop: when uart_in_valid && avail.
  - rd_ptr advances and read_cnt increments.
  - gap is loaded.
- Underflow: uart_in_valid && !avail increments underflow_cnt, returns IDLE_CHAR and changes no FIFO state. This covers both the empty case and the WAIT case.
- Simultaneous push and pop: both take effect and level is unchanged.
  - When empty, a same-cycle push is not visible; there is no bypass, and the character appears next cycle.
  - When full, a same-cycle pop does not free space for that cycle's push. push_ready is based on the registered level, so the push is refused and counted as overflow.
- push_ch is ignored when push_valid==0. uart_in_valid held high across consecutive cycles pops one character per READY cycle.
- Counters: 32-bit, saturate at 32'hffff_ffff; no wrap.
- level updates as level + push_accepted - pop, registered.

Test Plan:
- Reset then idle 5 cycles:
  - push_ready=1, avail=0, uart_in_ch=8'hff, level=0.
  - Assert uart_in_valid for 1 cycle -> underflow_cnt=1, read_cnt=0.
- GAP_CYCLES=0: push 'h','i' (8'h68, 8'h69) on consecutive cycles, then assert uart_in_valid for 3 cycles:
  - DUT sees 8'h68, 8'h69, then 8'hff.
  - read_cnt=2, underflow_cnt=1, level=0.
- DEPTH=16: push 18 characters back-to-back with no reads:
  - push_ready drops after the 16th; overflow_cnt=2, level=16.
  - Read all 16 -> values in push order, including across the pointer wrap.
- GAP_CYCLES=3: preload 8'h41, 8'h42, hold uart_in_valid high:
  - 8'h41 delivered at cycle t; 8'hff at t+1..t+3; 8'h42 at t+4.
  - underflow_cnt=3.
- Full FIFO with push_valid and uart_in_valid asserted in the same cycle:
  - Pop succeeds, push refused, overflow_cnt+1, level=15.
  - Next cycle a push is accepted -> level=16.
- Preload 4 characters, assert reset=0 for 1 cycle mid-stream:
  - level=0, avail=0, all counters 0.
  - Next uart_in_valid returns 8'hff.
